// File: rtl/alu_mdu_seq.sv
// Execute unit: single-cycle base integer ALU plus iterative RV32M multiply/divide.
// Handshake: an op is taken when in_valid & in_ready; a result is consumed when out_valid & out_ready.
module alu_mdu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;
  localparam int W2  = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] ma_q, ma_d;
  logic [WIDTH-1:0] mb_q, mb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W2-1:0]    prod_q, prod_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             iter_op, a_sgn, b_sgn, a_neg, b_neg, div_zero;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [W2-1:0]    mul_next, mul_fin;
  logic [WIDTH:0]   div_shift;
  logic             div_borrow;
  logic [WIDTH-1:0] div_rem, quo_fin, rem_fin;
  logic [W2-1:0]    div_next;

  assign shamt = b[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (op)
      5'd0:  alu_res = a + b;
      5'd1:  alu_res = a - b;
      5'd2:  alu_res = a & b;
      5'd3:  alu_res = a | b;
      5'd4:  alu_res = a ^ b;
      5'd5:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      5'd6:  alu_res = {{(WIDTH-1){1'b0}}, a < b};
      5'd7:  alu_res = a << shamt;
      5'd8:  alu_res = $signed(a) >>> shamt;
      5'd9:  alu_res = a >> shamt;
      5'd10: alu_res = b;
      5'd11: alu_res = a;
      default: alu_res = '0;
    endcase
  end

  // Iterative ops work on magnitudes; signs are folded back in at the end.
  assign iter_op  = (op[4:3] == 2'b10);
  assign a_sgn    = (op == 5'd17) | (op == 5'd18) | (op == 5'd20) | (op == 5'd22);
  assign b_sgn    = (op == 5'd17) | (op == 5'd20) | (op == 5'd22);
  assign a_neg    = a_sgn & a[WIDTH-1];
  assign b_neg    = b_sgn & b[WIDTH-1];
  assign a_mag    = a_neg ? -a : a;
  assign b_mag    = b_neg ? -b : b;
  assign div_zero = (b == '0);

  // Shift-add: multiplier sits in the low half and is consumed LSB first.
  assign mul_sum  = {1'b0, prod_q[W2-1:WIDTH]} + {1'b0, (prod_q[0] ? ma_q : {WIDTH{1'b0}})};
  assign mul_next = {mul_sum, prod_q[WIDTH-1:1]};
  assign mul_fin  = neg_q ? -mul_next : mul_next;

  // Restoring divide: remainder in the high half, dividend/quotient in the low half.
  assign div_shift  = {prod_q[W2-1:WIDTH], prod_q[WIDTH-1]};
  assign div_borrow = div_shift < {1'b0, mb_q};
  assign div_rem    = div_borrow ? div_shift[WIDTH-1:0] : (div_shift[WIDTH-1:0] - mb_q);
  assign div_next   = {div_rem, prod_q[WIDTH-2:0], ~div_borrow};
  assign quo_fin    = neg_q ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
  assign rem_fin    = neg_q ? -div_next[W2-1:WIDTH] : div_next[W2-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    neg_d    = neg_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    result_d = result_q;
    if (flush) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      result_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            if (!iter_op) begin
              result_d = alu_res;
              state_d  = S_DONE;
            end else begin
              sel_d = op[1:0];
              neg_d = (op[2] & op[1]) ? a_neg : (a_neg ^ b_neg);
              cnt_d = CW'(WIDTH);
              if (!op[2]) begin
                state_d = S_MUL;
                ma_d    = a_mag;
                prod_d  = {{WIDTH{1'b0}}, b_mag};
              end else if (div_zero) begin
                state_d  = S_DONE;
                cnt_d    = '0;
                result_d = op[1] ? a : {WIDTH{1'b1}};
              end else begin
                state_d = S_DIV;
                mb_d    = b_mag;
                prod_d  = {{WIDTH{1'b0}}, a_mag};
              end
            end
          end
        end
        S_MUL: begin
          prod_d = mul_next;
          cnt_d  = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d  = S_DONE;
            result_d = (sel_q == 2'd0) ? mul_fin[WIDTH-1:0] : mul_fin[W2-1:WIDTH];
          end
        end
        S_DIV: begin
          prod_d = div_next;
          cnt_d  = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d  = S_DONE;
            result_d = sel_q[1] ? rem_fin : quo_fin;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_d  = S_IDLE;
            result_d = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    out_valid_d = (state_d == S_DONE);
    in_ready_d  = (state_d == S_IDLE);
    busy_d      = (state_d == S_MUL) || (state_d == S_DIV);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sel_q       <= '0;
      neg_q       <= 1'b0;
      ma_q        <= '0;
      mb_q        <= '0;
      cnt_q       <= '0;
      prod_q      <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      neg_q       <= neg_d;
      ma_q        <= ma_d;
      mb_q        <= mb_d;
      cnt_q       <= cnt_d;
      prod_q      <= prod_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_alu_mdu_seq.sv
// Bench for alu_mdu_seq: 32-bit instance for the main scenarios, 8-bit instance for the narrow build.
module tb_alu_mdu_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [4:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, busy;
  logic [W-1:0] result;

  logic         in_valid8 = 1'b0;
  logic         out_ready8 = 1'b0;
  logic [4:0]   op8 = '0;
  logic [7:0]   a8 = '0;
  logic [7:0]   b8 = '0;
  logic         in_ready8, out_valid8, busy8;
  logic [7:0]   result8;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  alu_mdu_seq #(.WIDTH(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  alu_mdu_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid8), .in_ready(in_ready8),
    .op(op8), .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
    .result(result8), .busy(busy8)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model built on native 64-bit arithmetic.
  function automatic logic [31:0] ref32(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    logic [63:0] p;
    logic [31:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r  = '0;
    p  = '0;
    case (o)
      5'd0:  r = x + y;
      5'd1:  r = x - y;
      5'd2:  r = x & y;
      5'd3:  r = x | y;
      5'd4:  r = x ^ y;
      5'd5:  r = (sx < sy) ? 32'd1 : 32'd0;
      5'd6:  r = (x < y) ? 32'd1 : 32'd0;
      5'd7:  r = x << y[4:0];
      5'd8:  r = $signed(x) >>> y[4:0];
      5'd9:  r = x >> y[4:0];
      5'd10: r = y;
      5'd11: r = x;
      5'd16: begin p = {32'b0, x} * {32'b0, y}; r = p[31:0]; end
      5'd17: begin p = sx * sy; r = p[63:32]; end
      5'd18: begin p = sx * longint'({32'b0, y}); r = p[63:32]; end
      5'd19: begin p = {32'b0, x} * {32'b0, y}; r = p[63:32]; end
      5'd20: begin
        if (y == 0) r = 32'hFFFFFFFF;
        else begin p = sx / sy; r = p[31:0]; end
      end
      5'd21: r = (y == 0) ? 32'hFFFFFFFF : x / y;
      5'd22: begin
        if (y == 0) r = x;
        else begin p = sx % sy; r = p[31:0]; end
      end
      5'd23: r = (y == 0) ? x : x % y;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Driver: waits for in_ready, presents one op for one accepting edge, queues its expectation.
  task automatic send(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y, input logic [31:0] e);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_wait: in_ready=%b required 1 within 200 cycles", in_ready);
    end
    op = o; a = x; b = y; in_valid = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Waits for out_valid; lat counts cycles since the accepting edge.
  task automatic wait_out(output logic [31:0] r, output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL wait_out: out_valid=%b required 1 within 200 cycles", out_valid);
    end
    r = result;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (result !== '0) begin errors++; $display("FAIL reset_result: got %h required 0", result); end
    checks++; if (in_ready8 !== 1'b1) begin errors++; $display("FAIL reset_in_ready8: got %b required 1", in_ready8); end
  endtask

  task automatic test_alu();
    logic [4:0]  vo[8] = '{5'd0, 5'd8, 5'd5, 5'd6, 5'd13, 5'd1, 5'd7, 5'd10};
    logic [31:0] va[8] = '{32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678, 32'd5, 32'h00000003, 32'h1};
    logic [31:0] vb[8] = '{32'h1, 32'h24, 32'h1, 32'h1, 32'h9, 32'd7, 32'h00000021, 32'hCAFEF00D};
    logic [31:0] ve[8] = '{32'h0, 32'hF8000000, 32'h1, 32'h0, 32'h0, 32'hFFFFFFFE, 32'h6, 32'hCAFEF00D};
    logic [31:0] r, e;
    int lat;
    for (int i = 0; i < 8; i++) begin
      send(vo[i], va[i], vb[i], ve[i]);
      wait_out(r, lat);
      e = exp_q.pop_front();
      checks++; if (r !== e) begin errors++; $display("FAIL alu_%0d op=%0d: result=%h required %h", i, vo[i], r, e); end
      checks++; if (lat !== 1) begin errors++; $display("FAIL alu_lat_%0d: latency=%0d required 1", i, lat); end
      consume();
    end
  endtask

  task automatic test_mul();
    logic [4:0]  vo[5] = '{5'd16, 5'd17, 5'd19, 5'd18, 5'd16};
    logic [31:0] va[5] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd6};
    logic [31:0] vb[5] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7};
    logic [31:0] ve[5] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd42};
    logic [31:0] r, e;
    int lat;
    for (int i = 0; i < 5; i++) begin
      send(vo[i], va[i], vb[i], ve[i]);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mul_busy_%0d: busy=%b required 1", i, busy); end
      wait_out(r, lat);
      e = exp_q.pop_front();
      checks++; if (r !== e) begin errors++; $display("FAIL mul_%0d op=%0d: result=%h required %h", i, vo[i], r, e); end
      checks++; if (lat !== W + 1) begin errors++; $display("FAIL mul_lat_%0d: latency=%0d required %0d", i, lat, W + 1); end
      consume();
    end
  endtask

  task automatic test_div();
    logic [4:0]  vo[8] = '{5'd20, 5'd22, 5'd21, 5'd23, 5'd20, 5'd22, 5'd20, 5'd22};
    logic [31:0] va[8] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd9, 32'd5, 32'h80000000, 32'h80000000};
    logic [31:0] vb[8] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] ve[8] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0};
    logic [31:0] r, e;
    int lat;
    for (int i = 0; i < 8; i++) begin
      send(vo[i], va[i], vb[i], ve[i]);
      wait_out(r, lat);
      e = exp_q.pop_front();
      checks++; if (r !== e) begin errors++; $display("FAIL div_%0d op=%0d: result=%h required %h", i, vo[i], r, e); end
      if (vb[i] != 0) begin
        checks++; if (lat !== W + 1) begin errors++; $display("FAIL div_lat_%0d: latency=%0d required %0d", i, lat, W + 1); end
      end
      consume();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] r, e;
    int lat;
    send(5'd4, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'hAAAAAAAA);
    wait_out(r, lat);
    e = exp_q.pop_front();
    checks++; if (r !== e) begin errors++; $display("FAIL bp_result: result=%h required %h", r, e); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (result !== e) begin errors++; $display("FAIL bp_hold_%0d: result=%h required %h", i, result, e); end
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++; $display("FAIL bp_flags_%0d: in_ready=%b out_valid=%b required 0 1", i, in_ready, out_valid);
      end
    end
    consume();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
    checks++; if (result !== '0) begin errors++; $display("FAIL bp_idle_result: result=%h required 0", result); end
  endtask

  task automatic test_flush();
    logic [31:0] r, e;
    int lat;
    bit seen;
    // An op presented together with flush in IDLE must not be taken.
    op = 5'd0; a = 32'd1; b = 32'd1; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_prio: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
    send(5'd20, 32'd1000, 32'd3, 32'd333);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    void'(exp_q.pop_back());
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL flush_state: in_ready=%b out_valid=%b busy=%b required 1 0 0", in_ready, out_valid, busy);
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_output: out_valid seen=%b required 0", seen); end
    send(5'd0, 32'd2, 32'd3, 32'd5);
    wait_out(r, lat);
    e = exp_q.pop_front();
    checks++; if (r !== e) begin errors++; $display("FAIL flush_add: result=%h required %h", r, e); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL flush_add_lat: latency=%0d required 1", lat); end
    consume();
  endtask

  task automatic test_reset_mid_mul();
    logic [31:0] r, e;
    int lat;
    send(5'd16, 32'd12345, 32'd678, 32'd8369910);
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    op = 5'd0; a = 32'd1; b = 32'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    void'(exp_q.pop_back());
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || result !== '0) begin
      errors++; $display("FAIL rst_mid: out_valid=%b busy=%b result=%h required 0 0 0", out_valid, busy, result);
    end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b required 1", in_ready); end
    send(5'd16, 32'd6, 32'd7, 32'd42);
    wait_out(r, lat);
    e = exp_q.pop_front();
    checks++; if (r !== e) begin errors++; $display("FAIL rst_mul: result=%h required %h", r, e); end
    checks++; if (lat !== W + 1) begin errors++; $display("FAIL rst_mul_lat: latency=%0d required %0d", lat, W + 1); end
    consume();
  endtask

  task automatic test_back_to_back();
    logic [31:0] r, e, x, y;
    logic [4:0] o;
    int lat, exp_lat;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      o = 5'($urandom_range(0, 31));
      x = $urandom;
      y = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if (i % 3 == 1) y = 32'($urandom_range(1, 300));
      exp_lat = (o[4:3] == 2'b10) ? W + 1 : 1;
      send(o, x, y, ref32(o, x, y));
      wait_out(r, lat);
      e = exp_q.pop_front();
      checks++; if (r !== e) begin errors++; $display("FAIL b2b_%0d op=%0d a=%h b=%h: result=%h required %h", i, o, x, y, r, e); end
      if (!(o >= 5'd20 && o <= 5'd23 && y == 0)) begin
        checks++; if (lat !== exp_lat) begin errors++; $display("FAIL b2b_lat_%0d: latency=%0d required %0d", i, lat, exp_lat); end
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL b2b_queue: leftover=%0d required 0", exp_q.size()); end
  endtask

  task automatic test_width8();
    logic [4:0] vo[2] = '{5'd17, 5'd21};
    logic [7:0] va[2] = '{8'h80, 8'd200};
    logic [7:0] vb[2] = '{8'h80, 8'd3};
    logic [7:0] ve[2] = '{8'h40, 8'd66};
    logic [31:0] e;
    int lat;
    for (int i = 0; i < 2; i++) begin
      op8 = vo[i]; a8 = va[i]; b8 = vb[i]; in_valid8 = 1'b1;
      exp_q.push_back({24'b0, ve[i]});
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      lat = 1;
      while (!out_valid8 && lat < 50) begin
        @(posedge clk); #1;
        lat++;
      end
      e = exp_q.pop_front();
      checks++; if ({24'b0, result8} !== e) begin errors++; $display("FAIL w8_%0d: result=%h required %h", i, result8, e); end
      checks++; if (lat !== 9) begin errors++; $display("FAIL w8_lat_%0d: latency=%0d required 9", i, lat); end
      out_ready8 = 1'b1;
      @(posedge clk); #1;
      out_ready8 = 1'b0;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset();
    test_alu();
    test_mul();
    test_div();
    test_backpressure();
    test_flush();
    test_reset_mid_mul();
    test_back_to_back();
    test_width8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
